regfile_write_arbiter: RTL and testbench

//   Shares the 4x8-bit register file's single write port between two requesters:

---
 rtl/regfile_write_arbiter_pkg.sv | 18 +
 rtl/regfile_write_arbiter_rr_arbiter2.sv | 36 +++
 rtl/regfile_write_arbiter.sv | 106 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter and the register file it feeds.
package regfile_write_arbiter_pkg;

  // Register file geometry shared with the register file itself.
  localparam int unsigned RF_DATA_W   = 8;
  localparam int unsigned RF_ADDR_W   = 2;
  localparam int unsigned RF_NUM_REGS = 4;

  // Encoding of last_grant.
  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Two-input round-robin grant logic with the last_grant history register.
module regfile_write_arbiter_rr_arbiter2
  import regfile_write_arbiter_pkg::*;
(
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  input  logic i_req_a,
  input  logic i_req_b,
  output logic o_gnt_a,
  output logic o_gnt_b,
  output logic o_last_grant
);

  logic r_last;

  // On a tie the port that did not win last time is granted.
  always_comb begin
    o_gnt_a = i_en && i_req_a && (!i_req_b || (r_last == GRANT_B));
    o_gnt_b = i_en && i_req_b && (!i_req_a || (r_last == GRANT_A));
  end

  // Remember the most recent winner; starts at B so A wins the first tie.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_last <= GRANT_B;
    end else if (o_gnt_a) begin
      r_last <= GRANT_A;
    end else if (o_gnt_b) begin
      r_last <= GRANT_B;
    end
  end

  assign o_last_grant = r_last;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates two write requesters onto the register file's single write port, with a
// registered write stage and a sequenced clear-all sweep.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter int unsigned NUM_REGS = RF_NUM_REGS
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_a_valid,
  output logic              o_a_ready,
  input  logic [ADDR_W-1:0] i_a_reg,
  input  logic [DATA_W-1:0] i_a_data,
  input  logic              i_b_valid,
  output logic              o_b_ready,
  input  logic [ADDR_W-1:0] i_b_reg,
  input  logic [DATA_W-1:0] i_b_data,
  input  logic              i_clear_start,
  output logic              o_clear_busy,
  output logic              o_rf_write,
  output logic [ADDR_W-1:0] o_rf_write_reg,
  output logic [DATA_W-1:0] o_rf_write_data,
  output logic              o_last_grant
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_e            r_state;
  logic [ADDR_W-1:0] r_count;
  logic              r_clear_busy;
  logic              r_rf_write;
  logic [ADDR_W-1:0] r_rf_reg;
  logic [DATA_W-1:0] r_rf_data;

  logic w_arb_en;
  logic w_gnt_a;
  logic w_gnt_b;

  // Ports are only served in ARB, never while a clear is being requested or under reset.
  assign w_arb_en = (r_state == ST_ARB) && !i_clear_start && !i_reset;

  regfile_write_arbiter_rr_arbiter2 u_rr_arbiter2 (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_en         (w_arb_en),
    .i_req_a      (i_a_valid),
    .i_req_b      (i_b_valid),
    .o_gnt_a      (w_gnt_a),
    .o_gnt_b      (w_gnt_b),
    .o_last_grant (o_last_grant)
  );

  // Control FSM, clear sweep counter and registered write stage.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= ST_ARB;
      r_count      <= '0;
      r_clear_busy <= 1'b0;
      r_rf_write   <= 1'b0;
      r_rf_reg     <= '0;
      r_rf_data    <= '0;
    end else begin
      unique case (r_state)
        ST_ARB: begin
          if (i_clear_start) begin
            r_state      <= ST_CLEAR;
            r_clear_busy <= 1'b1;
            r_rf_write   <= 1'b0;
          end else if (w_gnt_a) begin
            r_rf_write <= 1'b1;
            r_rf_reg   <= i_a_reg;
            r_rf_data  <= i_a_data;
          end else if (w_gnt_b) begin
            r_rf_write <= 1'b1;
            r_rf_reg   <= i_b_reg;
            r_rf_data  <= i_b_data;
          end else begin
            r_rf_write <= 1'b0;
          end
        end
        ST_CLEAR: begin
          r_rf_write <= 1'b1;
          r_rf_reg   <= r_count;
          r_rf_data  <= '0;
          if (r_count == LAST_IDX) begin
            r_count      <= '0;
            r_state      <= ST_ARB;
            r_clear_busy <= 1'b0;
          end else begin
            r_count <= r_count + ADDR_W'(1);
          end
        end
      endcase
    end
  end

  assign o_a_ready       = w_gnt_a;
  assign o_b_ready       = w_gnt_b;
  assign o_clear_busy    = r_clear_busy;
  assign o_rf_write      = r_rf_write;
  assign o_rf_write_reg  = r_rf_reg;
  assign o_rf_write_data = r_rf_data;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench: stimulus pushes expected register-file writes, a negedge monitor
// pops and compares every write the DUT presents.
module tb_regfile_write_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_valid, b_valid, clear_start;
  logic       a_ready, b_ready, clear_busy;
  logic [1:0] a_reg, b_reg, rf_write_reg;
  logic [7:0] a_data, b_data, rf_write_data;
  logic       rf_write, last_grant;

  int checks = 0;
  int errors = 0;

  logic [9:0] exp_q[$];
  logic [9:0] exp_w;
  logic [7:0] rf_model[4];

  always #5 clk = ~clk;

  regfile_write_arbiter dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_a_valid       (a_valid),
    .o_a_ready       (a_ready),
    .i_a_reg         (a_reg),
    .i_a_data        (a_data),
    .i_b_valid       (b_valid),
    .o_b_ready       (b_ready),
    .i_b_reg         (b_reg),
    .i_b_data        (b_data),
    .i_clear_start   (clear_start),
    .o_clear_busy    (clear_busy),
    .o_rf_write      (rf_write),
    .o_rf_write_reg  (rf_write_reg),
    .o_rf_write_data (rf_write_data),
    .o_last_grant    (last_grant)
  );

  // Monitor: the register file commits in the low phase, so sample on negedge.
  always @(negedge clk) begin
    if (!reset && rf_write) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rf_write_unexpected got reg=%0d data=%h required no write",
                 rf_write_reg, rf_write_data);
      end else begin
        exp_w = exp_q.pop_front();
        if ({rf_write_reg, rf_write_data} !== exp_w) begin
          errors++;
          $display("FAIL rf_write got reg=%0d data=%h required reg=%0d data=%h",
                   rf_write_reg, rf_write_data, exp_w[9:8], exp_w[7:0]);
        end
      end
      rf_model[rf_write_reg] = rf_write_data;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, req);
    end
  endtask

  // One cycle of stimulus; inputs are applied 1ns after posedge, outputs checked at negedge.
  task automatic cyc(input logic av, input logic bv, input logic cs,
                     input logic exp_ar, input logic exp_br, input logic exp_busy);
    a_valid     = av;
    b_valid     = bv;
    clear_start = cs;
    @(negedge clk);
    check("a_ready", 32'(a_ready), 32'(exp_ar));
    check("b_ready", 32'(b_ready), 32'(exp_br));
    check("clear_busy", 32'(clear_busy), 32'(exp_busy));
    if (exp_ar) exp_q.push_back({a_reg, a_data});
    if (exp_br) exp_q.push_back({b_reg, b_data});
    @(posedge clk);
    #1;
  endtask

  task automatic push_clear();
    for (int r = 0; r < 4; r++) exp_q.push_back({2'(r), 8'h00});
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    for (int r = 0; r < 4; r++) rf_model[r] = 8'hFF;
    reset = 1'b1; clear_start = 1'b0;
    a_valid = 1'b1; a_reg = 2'd2; a_data = 8'h5C;
    b_valid = 1'b0; b_reg = 2'd0; b_data = 8'h00;

    // 1. Reset state with a_valid held, then first transfer.
    @(posedge clk); #1; @(posedge clk); #1;
    check("rst_rf_write", 32'(rf_write), 32'd0);
    check("rst_rf_reg", 32'(rf_write_reg), 32'd0);
    check("rst_rf_data", 32'(rf_write_data), 32'd0);
    check("rst_clear_busy", 32'(clear_busy), 32'd0);
    check("rst_a_ready", 32'(a_ready), 32'd0);
    check("rst_b_ready", 32'(b_ready), 32'd0);
    check("rst_last_grant", 32'(last_grant), 32'd1);
    reset = 1'b0;
    cyc(1, 0, 0, 1, 0, 0);
    check("t1_rf_write", 32'(rf_write), 32'd1);
    cyc(0, 0, 0, 0, 0, 0);
    check("t1_last_grant", 32'(last_grant), 32'd0);
    pulse_reset();

    // 2. Both valid: alternate A, B, A, B.
    a_reg = 2'd1; a_data = 8'h11; b_reg = 2'd2; b_data = 8'h22;
    cyc(1, 1, 0, 1, 0, 0);
    cyc(1, 1, 0, 0, 1, 0);
    cyc(1, 1, 0, 1, 0, 0);
    check("t2_rf_write_b", 32'(rf_write), 32'd1);
    cyc(1, 1, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("t2_last_grant", 32'(last_grant), 32'd1);

    // 3. Same destination: A then B, B's value persists.
    a_reg = 2'd3; a_data = 8'hAA; b_reg = 2'd3; b_data = 8'hBB;
    cyc(1, 1, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("t3_r3", 32'(rf_model[3]), 32'hBB);

    // 4. Clear with both ports waiting; A wins afterwards (last grant was B).
    a_reg = 2'd0; a_data = 8'h33; b_reg = 2'd1; b_data = 8'h44;
    cyc(1, 1, 1, 0, 0, 0);
    push_clear();
    repeat (4) cyc(1, 1, 0, 0, 0, 1);
    cyc(1, 1, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("t4_last_grant", 32'(last_grant), 32'd0);
    check("t4_r0", 32'(rf_model[0]), 32'h33);

    // 5. Second clear_start inside a sweep is ignored.
    cyc(0, 0, 1, 0, 0, 0);
    push_clear();
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    for (int r = 0; r < 4; r++) check($sformatf("t5_r%0d", r), 32'(rf_model[r]), 32'd0);

    // 6. Reset on the second clear cycle drops the sweep.
    b_reg = 2'd3; b_data = 8'hA5; a_reg = 2'd2; a_data = 8'h5A;
    cyc(0, 1, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("t6_last_grant_pre", 32'(last_grant), 32'd0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    reset = 1'b1;
    #1;
    check("t6_rf_write", 32'(rf_write), 32'd0);
    check("t6_clear_busy", 32'(clear_busy), 32'd0);
    check("t6_last_grant", 32'(last_grant), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) cyc(0, 0, 0, 0, 0, 0);
    check("t6_r2", 32'(rf_model[2]), 32'h5A);
    check("t6_r3", 32'(rf_model[3]), 32'hA5);
    check("pending_writes", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
